// File: rtl/rnn_pkg.sv
// Shared definitions for the RNN layer sequencer: layer indices, GRU mask,
// GRU-to-commit-bit mapping and FSM state encoding.
package rnn_pkg;

    typedef logic [2:0] layer_idx_t;

    localparam layer_idx_t L_DENSE1 = 3'd0;
    localparam layer_idx_t L_GRU1   = 3'd1;
    localparam layer_idx_t L_DENSE2 = 3'd2;
    localparam layer_idx_t L_GRU2   = 3'd3;
    localparam layer_idx_t L_GRU3   = 3'd4;
    localparam layer_idx_t L_DENSE3 = 3'd5;

    // Bit set for every layer that owns recurrent state
    localparam logic [5:0] GRU_MASK = 6'b011010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_COMMIT,
        S_DONE,
        S_ERR
    } seq_state_t;

    // Which shadow state register a GRU layer commits: vad, noise, denoise
    function automatic logic [2:0] commit_bits(input layer_idx_t li);
        logic [2:0] bits;
        bits = '0;
        case (li)
            L_GRU1:  bits = 3'b001;
            L_GRU2:  bits = 3'b010;
            L_GRU3:  bits = 3'b100;
            default: bits = '0;
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/rnn_seq_watchdog.sv
// Per-layer watchdog: counts WAIT cycles since the last launch and flags
// expiry on the WDOG_CYCLES-th consecutive WAIT cycle.
// Used only when RNN_SEQ_WATCHDOG_EN is defined.
module rnn_seq_watchdog #(
    parameter int unsigned WDOG_CYCLES = 65536,
    parameter int unsigned WDOG_W      = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    logic [WDOG_W-1:0] cnt;

    // Counter: cleared at launch, advances once per WAIT cycle
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (count_en) begin
            cnt <= cnt + WDOG_W'(1);
        end
    end

    // Expiry is raised during the last permitted WAIT cycle
    always_comb begin
        expired = count_en && (cnt == WDOG_W'(WDOG_CYCLES - 1));
    end

endmodule

// File: rtl/rnn_layer_sequencer.sv
// Frame-level controller for the fixed-point RNN denoiser. Launches
// dense1, gru1, dense2, gru2, gru3, dense3 in turn, waits for each done,
// and pulses a state commit after every GRU layer.
// Optional feature macro: RNN_SEQ_WATCHDOG_EN (per-layer WAIT watchdog).
module rnn_layer_sequencer
    import rnn_pkg::*;
#(
    parameter int unsigned FRAME_CNT_W = 16,
    parameter int unsigned WDOG_CYCLES = 65536,
    parameter int unsigned WDOG_W      = 17
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start_i,
    input  logic                   state_reset_i,
    input  logic [5:0]             layer_done_i,
    output logic [5:0]             layer_start_o,
    output logic [2:0]             layer_sel_o,
    output logic [2:0]             state_commit_o,
    output logic                   clear_state_o,
    output logic                   busy_o,
    output logic                   frame_done_o,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o,
    output logic                   overrun_o,
    output logic                   error_o
);

    seq_state_t state, state_n;
    layer_idx_t li, li_n;

    logic [5:0] start_n;
    logic [2:0] sel_n;
    logic [2:0] commit_n;
    logic       clear_n;
    logic       busy_n;
    logic       done_n;

    if ($clog2(WDOG_CYCLES + 1) > WDOG_W) begin : g_bad_wdog_w
        $error("WDOG_W too narrow to hold WDOG_CYCLES");
    end

`ifdef RNN_SEQ_WATCHDOG_EN
    logic wdog_expired;

    rnn_seq_watchdog #(
        .WDOG_CYCLES(WDOG_CYCLES),
        .WDOG_W     (WDOG_W)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == S_LAUNCH),
        .count_en(state == S_WAIT),
        .expired (wdog_expired)
    );

    // Sticky error flag, set on entry to ERR
    always_ff @(posedge clk) begin
        if (rst) begin
            error_o <= 1'b0;
        end else if (state_n == S_ERR) begin
            error_o <= 1'b1;
        end
    end
`else
    assign error_o = 1'b0;
`endif

    // State register plus registered outputs, frame counter and overrun flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            li             <= '0;
            layer_start_o  <= '0;
            layer_sel_o    <= '0;
            state_commit_o <= '0;
            clear_state_o  <= 1'b0;
            busy_o         <= 1'b0;
            frame_done_o   <= 1'b0;
            frame_cnt_o    <= '0;
            overrun_o      <= 1'b0;
        end else begin
            state          <= state_n;
            li             <= li_n;
            layer_start_o  <= start_n;
            layer_sel_o    <= sel_n;
            state_commit_o <= commit_n;
            clear_state_o  <= clear_n;
            busy_o         <= busy_n;
            frame_done_o   <= done_n;
            if (state_n == S_DONE) begin
                frame_cnt_o <= frame_cnt_o + FRAME_CNT_W'(1);
            end
            if (frame_start_i && (state != S_IDLE) && (state != S_ERR)) begin
                overrun_o <= 1'b1;
            end
        end
    end

    // Next-state: only the active layer's done bit is honoured, and only in WAIT
    always_comb begin
        state_n = state;
        li_n    = li;
        case (state)
            S_IDLE: begin
                if (frame_start_i) begin
                    li_n    = L_DENSE1;
                    state_n = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (layer_done_i[li]) begin
                    if (GRU_MASK[li]) begin
                        state_n = S_COMMIT;
                    end else if (li == L_DENSE3) begin
                        state_n = S_DONE;
                    end else begin
                        li_n    = li + 3'd1;
                        state_n = S_LAUNCH;
                    end
                end
`ifdef RNN_SEQ_WATCHDOG_EN
                else if (wdog_expired) begin
                    state_n = S_ERR;
                end
`endif
            end
            S_COMMIT: begin
                li_n    = li + 3'd1;
                state_n = S_LAUNCH;
            end
            S_DONE: begin
                li_n    = '0;
                state_n = S_IDLE;
            end
            S_ERR: begin
                state_n = S_ERR;
            end
            default: begin
                li_n    = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output lands in a register
    always_comb begin
        start_n  = '0;
        sel_n    = '0;
        commit_n = '0;
        clear_n  = 1'b0;
        busy_n   = 1'b0;
        done_n   = 1'b0;
        case (state_n)
            S_LAUNCH: begin
                start_n = 6'b000001 << li_n;
                sel_n   = li_n;
                busy_n  = 1'b1;
                clear_n = (state == S_IDLE) && state_reset_i;
            end
            S_WAIT: begin
                sel_n  = li_n;
                busy_n = 1'b1;
            end
            S_COMMIT: begin
                commit_n = commit_bits(li_n);
                sel_n    = li_n;
                busy_n   = 1'b1;
            end
            S_DONE: begin
                done_n = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rnn_layer_sequencer.sv
// Directed bench for rnn_layer_sequencer: table of whole-frame vectors
// (per-layer done delays with hand-computed latencies) plus hand-written
// reset-mid-frame and post-reset sequences.
module tb_rnn_layer_sequencer;

    logic        clk;
    logic        rst;
    logic        frame_start_i;
    logic        state_reset_i;
    logic [5:0]  layer_done_i;
    logic [5:0]  layer_start_o;
    logic [2:0]  layer_sel_o;
    logic [2:0]  state_commit_o;
    logic        clear_state_o;
    logic        busy_o;
    logic        frame_done_o;
    logic [15:0] frame_cnt_o;
    logic        overrun_o;
    logic        error_o;

    int n_vec = 0;
    int n_err = 0;

    rnn_layer_sequencer #(
        .FRAME_CNT_W(16),
        .WDOG_CYCLES(65536),
        .WDOG_W     (17)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start_i (frame_start_i),
        .state_reset_i (state_reset_i),
        .layer_done_i  (layer_done_i),
        .layer_start_o (layer_start_o),
        .layer_sel_o   (layer_sel_o),
        .state_commit_o(state_commit_o),
        .clear_state_o (clear_state_o),
        .busy_o        (busy_o),
        .frame_done_o  (frame_done_o),
        .frame_cnt_o   (frame_cnt_o),
        .overrun_o     (overrun_o),
        .error_o       (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int delay [6];    // cycles from start visible to done driven
        bit state_reset;
        bit spur;         // inject stray done bits around dense1
        int ovr_at;       // cycle to pulse frame_start mid-frame (0 = none)
        int exp_lat;      // cycles from start acceptance to frame_done
        bit exp_ovr;
        int exp_cnt;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] exp_commit(input int li);
        case (li)
            1:       return 3'b001;
            3:       return 3'b010;
            4:       return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit is_gru(input int li);
        return (li == 1) || (li == 3) || (li == 4);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int  next_li;
        int  cur_li;
        int  start_n;
        int  done_n;
        int  last_done_n;
        int  starts;
        bit  prev_gru;
        bit  finished;
        logic [5:0] one_hot;

        frame_start_i = 1'b1;
        state_reset_i = v.state_reset;
        layer_done_i  = '0;
        tick();
        frame_start_i = 1'b0;
        state_reset_i = 1'b0;

        next_li = 0; cur_li = 0; start_n = -10; done_n = -1;
        last_done_n = -1; starts = 0; prev_gru = 1'b0; finished = 1'b0;

        for (int n = 0; n < 3000 && !finished; n++) begin
            if (layer_start_o != 6'b0) begin
                one_hot = 6'b000001 << next_li;
                check("start_onehot", layer_start_o, one_hot);
                check("start_sel", layer_sel_o, next_li);
                check("start_gap", n - last_done_n, (next_li != 0 && prev_gru) ? 2 : 1);
                if (next_li == 0)
                    check("clear_with_start0", clear_state_o, v.state_reset);
                cur_li  = next_li;
                start_n = n;
                done_n  = n + v.delay[cur_li];
                starts++;
            end
            if (state_commit_o != 3'b0) begin
                check("commit_bits", state_commit_o, exp_commit(cur_li));
                check("commit_gap", n - last_done_n, 1);
            end
            if (frame_done_o) begin
                check("frame_latency", n, v.exp_lat);
                check("busy_at_done", busy_o, 0);
                check("frame_cnt", frame_cnt_o, v.exp_cnt);
                check("start_count", starts, 6);
                finished = 1'b1;
            end else begin
                check("busy_in_frame", busy_o, 1);
            end

            layer_done_i = '0;
            if (!finished && n == done_n) begin
                layer_done_i[cur_li] = 1'b1;
                last_done_n = n;
                prev_gru    = is_gru(cur_li);
                next_li     = cur_li + 1;
            end
            if (v.spur && cur_li == 0 && n == start_n)     layer_done_i[0] = 1'b1;
            if (v.spur && cur_li == 0 && n == start_n + 1) layer_done_i[3] = 1'b1;
            frame_start_i = (v.ovr_at != 0) && (n == v.ovr_at);
            tick();
        end
        if (!finished) check("frame_timeout", 0, 1);
        frame_start_i = 1'b0;
        layer_done_i  = '0;
        check("done_pulse_low", frame_done_o, 0);
        check("overrun_after_frame", overrun_o, v.exp_ovr);
    endtask

    initial begin
        logic [5:0] pend;
        bit         reached;

        //                delays               sr spur ovr lat  ovr cnt
        vecs[0] = '{'{1, 1, 1, 1, 1, 1},        0, 0,  0,  15,  0,  1};
        vecs[1] = '{'{40, 3, 7, 120, 250, 9},   0, 0,  0,  438, 0,  2};
        vecs[2] = '{'{3, 1, 1, 1, 1, 1},        0, 1,  0,  17,  0,  3};
        vecs[3] = '{'{1, 1, 1, 1, 1, 1},        0, 0,  8,  15,  1,  4};
        vecs[4] = '{'{1, 1, 1, 1, 1, 1},        1, 0,  0,  15,  1,  5};
        vecs[5] = '{'{2, 5, 1, 3, 1, 4},        1, 0,  0,  25,  1,  6};

        rst = 1'b1; frame_start_i = 1'b0; state_reset_i = 1'b0; layer_done_i = '0;
        repeat (3) tick();
        check("rst_start", layer_start_o, 0);
        check("rst_sel", layer_sel_o, 0);
        check("rst_commit", state_commit_o, 0);
        check("rst_clear", clear_state_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", frame_done_o, 0);
        check("rst_cnt", frame_cnt_o, 0);
        check("rst_overrun", overrun_o, 0);
        check("rst_error", error_o, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
            tick();
        end

        // Reset asserted in gru3 WAIT, together with gru3's done
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
        pend = '0;
        reached = 1'b0;
        for (int n = 0; n < 100 && !reached; n++) begin
            if (pend == 6'b010000) begin
                layer_done_i = pend;
                rst = 1'b1;
                reached = 1'b1;
            end else begin
                layer_done_i = pend;
                pend = layer_start_o;
                tick();
            end
        end
        check("reached_gru3_wait", reached, 1);
        tick();
        check("midrst_start", layer_start_o, 0);
        check("midrst_sel", layer_sel_o, 0);
        check("midrst_commit", state_commit_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_done", frame_done_o, 0);
        check("midrst_cnt", frame_cnt_o, 0);
        check("midrst_overrun", overrun_o, 0);
        rst = 1'b0;
        layer_done_i = '0;
        tick();
        check("postrst_commit", state_commit_o, 0);
        check("postrst_busy", busy_o, 0);
        check("postrst_start", layer_start_o, 0);

        // Fresh frame with state clear, then a dropped start during LAUNCH
        frame_start_i = 1'b1;
        state_reset_i = 1'b1;
        tick();
        state_reset_i = 1'b0;
        check("fresh_start0", layer_start_o, 6'b000001);
        check("fresh_clear", clear_state_o, 1);
        check("fresh_busy", busy_o, 1);
        check("fresh_overrun", overrun_o, 0);
        tick();
        frame_start_i = 1'b0;
        check("launch_drop_overrun", overrun_o, 1);
        check("launch_drop_nostart", layer_start_o, 0);
        check("launch_drop_clear", clear_state_o, 0);
        check("launch_drop_busy", busy_o, 1);
        check("no_error", error_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
